// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to the data memory write port, with
// combinational youngest-match load forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [31:0]   push_addr,
    input  logic [31:0]   push_data,
    input  logic [3:0]    push_be,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ready,
    input  logic [31:0]   ld_addr,
    output logic          ld_hit,
    output logic [31:0]   ld_data,
    output logic          ld_partial,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [AW-1:0]              rd_ptr, wr_ptr;
    logic [DEPTH-1:0][31:0]     addr_q, data_q;
    logic [DEPTH-1:0][3:0]      be_q;
    logic                       push, pop;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign push_ready = !full;
    assign mem_we     = !empty;
    assign push       = push_valid && push_ready;
    assign pop        = mem_we && mem_ready;

    // Head outputs are held at zero while empty so stale slots never show up.
    assign mem_addr  = mem_we ? {addr_q[rd_ptr][31:2], 2'b00} : '0;
    assign mem_wdata = mem_we ? data_q[rd_ptr] : '0;
    assign mem_be    = mem_we ? be_q[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                be_q[wr_ptr]   <= push_be;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    logic          match;
    logic [3:0]    match_be;
    logic [AW-1:0] idx;

    always_comb begin
        match    = 1'b0;
        match_be = '0;
        ld_data  = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if (((AW+1)'(i) < count) && (addr_q[idx][31:2] == ld_addr[31:2])) begin
                match    = 1'b1;
                match_be = be_q[idx];
                ld_data  = data_q[idx];
            end
        end
        ld_hit     = match && (match_be == 4'hF);
        ld_partial = match && (match_be != 4'hF);
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model, directed
// scenarios followed by randomized push/drain/load traffic.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          push_valid = 0;
    logic          push_ready;
    logic [31:0]   push_addr = 0;
    logic [31:0]   push_data = 0;
    logic [3:0]    push_be = 0;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready = 0;
    logic [31:0]   ld_addr = 0;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          ld_partial;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_data(push_data), .push_be(push_be),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_partial(ld_partial),
        .count(count), .empty(empty), .full(full)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Expected outputs straight from the queue contents and the current ld_addr.
    task automatic check_model(input string tag);
        int          n;
        logic        e_hit, e_part;
        logic [31:0] e_ld;
        n = q.size();
        e_hit = 0; e_part = 0; e_ld = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (q[i].a[31:2] == ld_addr[31:2]) begin
                e_ld   = q[i].d;
                e_hit  = (q[i].be == 4'hF);
                e_part = (q[i].be != 4'hF);
                break;
            end
        end
        chk({tag, ".count"},      32'(count),      32'(n));
        chk({tag, ".empty"},      32'(empty),      32'(n == 0));
        chk({tag, ".full"},       32'(full),       32'(n == DEPTH));
        chk({tag, ".push_ready"}, 32'(push_ready), 32'(n != DEPTH));
        chk({tag, ".mem_we"},     32'(mem_we),     32'(n != 0));
        chk({tag, ".mem_addr"},   mem_addr,  n != 0 ? {q[0].a[31:2], 2'b00} : 32'h0);
        chk({tag, ".mem_wdata"},  mem_wdata, n != 0 ? q[0].d : 32'h0);
        chk({tag, ".mem_be"},     32'(mem_be),     n != 0 ? 32'(q[0].be) : 32'h0);
        chk({tag, ".ld_hit"},     32'(ld_hit),     32'(e_hit));
        chk({tag, ".ld_partial"}, 32'(ld_partial), 32'(e_part));
        chk({tag, ".ld_data"},    ld_data,   e_ld);
    endtask

    // One clock: drive at negedge, check combinational outputs, then advance the model.
    task automatic step(input string tag, input bit pv, input logic [31:0] pa,
                        input logic [31:0] pd, input logic [3:0] pb,
                        input bit mr, input logic [31:0] la);
        bit do_pop, do_push;
        @(negedge clk);
        push_valid = pv; push_addr = pa; push_data = pd; push_be = pb;
        mem_ready = mr; ld_addr = la;
        #1;
        check_model(tag);
        do_pop  = (q.size() != 0) && mr;
        do_push = pv && (q.size() < DEPTH);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{a: pa, d: pd, be: pb});
        #1;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (q.size() != 0 && guard < DEPTH + 2) begin
            step(tag, 0, 0, 0, 0, 1, 0);
            guard++;
        end
        chk({tag, ".drain_done"}, 32'(q.size()), 32'h0);
    endtask

    initial begin
        // Reset state
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1;

        // Single push, one-cycle latency, then drain
        step("tp1_push", 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("tp1_we",   32'(mem_we), 32'h1);
        chk("tp1_addr", mem_addr,    32'h10);
        chk("tp1_cnt",  32'(count),  32'h1);
        step("tp1_pop", 0, 0, 0, 0, 1, 0);
        chk("tp1_cnt0",  32'(count), 32'h0);
        chk("tp1_empty", 32'(empty), 32'h1);

        // Fill, overflow push ignored, in-order drain
        for (int i = 0; i < DEPTH; i++)
            step("tp2_fill", 1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 0, 0);
        chk("tp2_full",  32'(full),       32'h1);
        chk("tp2_ready", 32'(push_ready), 32'h0);
        step("tp2_ovf", 1, 32'h100, 32'hBAD0BAD0, 4'hF, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step("tp2_drain", 0, 0, 0, 0, 0, 0);
            chk("tp2_order", mem_addr, 32'(i * 4));
            step("tp2_pop", 0, 0, 0, 0, 1, 0);
        end
        chk("tp2_empty", 32'(empty), 32'h1);

        // Full with push+pop: only the pop happens, push lands next cycle
        for (int i = 0; i < DEPTH; i++)
            step("tp3_fill", 1, 32'h200 + 32'(i * 4), 32'(i), 4'hF, 0, 0);
        step("tp3_both", 1, 32'h240, 32'h55, 4'hF, 1, 0);
        chk("tp3_cnt3", 32'(count), 32'h3);
        step("tp3_push", 1, 32'h240, 32'h55, 4'hF, 0, 0);
        chk("tp3_cnt4", 32'(count), 32'h4);
        drain("tp3");

        // Continuous streaming across pointer wrap
        step("tp4_first", 1, 32'h300, 32'h0, 4'hF, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step("tp4_stream", 1, 32'h300 + 32'(i * 4), 32'(i), 4'hF, 1, 0);
            chk("tp4_cnt", 32'(count), 32'h1);
        end
        drain("tp4");

        // Forwarding: youngest full-word match, then a younger partial
        step("tp5_a", 1, 32'h20, 32'h11111111, 4'hF, 0, 0);
        step("tp5_b", 1, 32'h20, 32'h22222222, 4'hF, 0, 0);
        @(negedge clk);
        push_valid = 0; mem_ready = 0; ld_addr = 32'h22;
        #1;
        chk("tp5_hit",  32'(ld_hit),     32'h1);
        chk("tp5_data", ld_data,         32'h22222222);
        chk("tp5_part", 32'(ld_partial), 32'h0);
        step("tp5_c", 1, 32'h20, 32'h000000FF, 4'h1, 0, 32'h22);
        @(negedge clk);
        push_valid = 0; ld_addr = 32'h22;
        #1;
        chk("tp5_hit2",  32'(ld_hit),     32'h0);
        chk("tp5_part2", 32'(ld_partial), 32'h1);
        chk("tp5_miss",  32'(1'b0), 32'(ld_hit && ld_partial));
        drain("tp5");

        // Asynchronous reset mid-drain
        for (int i = 0; i < 3; i++)
            step("tp6_fill", 1, 32'h400 + 32'(i * 4), 32'(i), 4'hF, 0, 0);
        @(negedge clk);
        push_valid = 0; mem_ready = 1; ld_addr = 32'h400;
        #2;
        rst_n = 0;
        #1;
        q.delete();
        chk("tp6_we",  32'(mem_we), 32'h0);
        chk("tp6_cnt", 32'(count),  32'h0);
        repeat (2) begin
            @(negedge clk);
            check_model("tp6_hold");
        end
        rst_n = 1;
        step("tp6_after", 0, 0, 0, 0, 1, 32'h400);

        // Randomized traffic over a small address window so loads often match
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pa, la;
            logic [3:0]  pb;
            pa = 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3));
            la = 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3));
            pb = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
            step("rnd", ($urandom_range(0, 2) != 0), pa, $urandom, pb,
                 ($urandom_range(0, 1) != 0), la);
        end
        drain("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
